// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns MIPS byte/half/word loads and stores into accesses
// on a word-only data memory. Sub-word stores are read-modify-write, and busy
// holds the pipeline while an access is in flight. Lanes are big-endian.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAPT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Reject misaligned, reserved-size and out-of-range requests before any memory access.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
            req_err = 1'b1;
        end
    end

    // Pick the addressed lane out of the read word, extend it, and build the merged store word.
    always_comb begin
        byte_lane = mem_rdata[31:24];
        case (addr_q[1:0])
            2'd1:    byte_lane = mem_rdata[23:16];
            2'd2:    byte_lane = mem_rdata[15:8];
            2'd3:    byte_lane = mem_rdata[7:0];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        load_ext = mem_rdata;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = uns_q ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = mem_rdata;
        endcase

        merged = mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                2'd3:    merged[7:0]   = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) begin
                merged[15:0] = wdata_q;
            end else begin
                merged[31:16] = wdata_q;
            end
        end
    end

    assign accept = req_valid && (state_q == IDLE);

    // Next-state logic; every output is decoded from the next state so it leaves a flop glitch-free.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata[15:0];
                    if (req_err) begin
                        err_d = 1'b1;
                    end else if (req_write && (req_size == 2'b10)) begin
                        mem_wdata_d = req_wdata;
                        state_d     = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:   state_d = CAPT;
            CAPT: begin
                if (write_q) begin
                    mem_wdata_d = merged;
                    state_d     = WR;
                end else begin
                    rd_data_d = load_ext;
                    state_d   = RESP;
                end
            end
            WR:   state_d = RESP;
            // RESP always drops back to IDLE, so a held request is only taken one cycle later.
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_read_d  = (state_d == RD);
        mem_write_d = (state_d == WR);
        busy_d      = (state_d == RD) || (state_d == CAPT) || (state_d == WR);
        done_d      = (state_d == RESP);
        rd_valid_d  = (state_d == RESP) && !write_d;
    end

    // State and output registers; reset drops any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 16'h0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rd_data_q   <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rd_data_q   <= rd_data_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = {2'b00, addr_q[31:2]};
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural word memory, hand-written vector
// table, reset and back-to-back sequences, and randomized requests checked
// against a lane-arithmetic reference model.
module tb_mem_access_ctrl;
    localparam int MEM_WORDS = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, rd_valid, done, err, mem_read, mem_write;
    logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: read data valid the cycle after the strobe, garbage otherwise.
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rd_buf = 32'h0;
    logic        rd_buf_valid = 1'b0;
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'h0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mem_write && mem_addr < 32'(MEM_WORDS)) mem[mem_addr[3:0]] <= mem_wdata;
        rd_buf_valid <= mem_read;
        if (mem_read && mem_addr < 32'(MEM_WORDS)) rd_buf <= mem[mem_addr[3:0]];
    end
    assign mem_rdata = rd_buf_valid ? rd_buf : 32'hDEAD_BEEF;

    // Strobe monitor: counts accesses and illegal strobe combinations.
    int read_cnt = 0;
    int write_cnt = 0;
    int bad_cnt = 0;
    always @(negedge clk) begin
        if (mem_read) read_cnt <= read_cnt + 1;
        if (mem_write) write_cnt <= write_cnt + 1;
        if ((mem_read && mem_write) || ((mem_read || mem_write) && mem_addr >= 32'(MEM_WORDS)))
            bad_cnt <= bad_cnt + 1;
    end

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_mem;
        logic        exp_err;
        logic        chk_mem;
        int          exp_lat;
        int          exp_rds;
        int          exp_wrs;
    } vec_t;

    vec_t        vecs [20];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] exp_rd_last;
    int          tests_run;
    int          tests_failed;

    int          res_lat, res_reads, res_writes, res_bad;
    logic        res_done, res_rv, res_err, res_prof_ok, res_quiet_ok;
    logic [31:0] res_rd;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = 4'(idx);
        pre_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Drive one request and record its response profile (bounded wait).
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
        int r0, w0, b0;
        @(negedge clk);
        #1;
        r0 = read_cnt; w0 = write_cnt; b0 = bad_cnt;
        res_prof_ok = (busy == 1'b0);
        req_write = w; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        res_lat = 0; res_done = 1'b0; res_rv = 1'b0; res_err = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (done || err) begin
                res_lat = c; res_done = done; res_rv = rd_valid; res_err = err;
                if (busy) res_prof_ok = 1'b0;
                break;
            end
            if (!busy || rd_valid) res_prof_ok = 1'b0;
        end
        req_valid = 1'b0;
        @(negedge clk);
        res_quiet_ok = !(done || rd_valid || err || busy || mem_read || mem_write);
        res_rd = rd_data;
        #1;
        res_reads = read_cnt - r0; res_writes = write_cnt - w0; res_bad = bad_cnt - b0;
    endtask

    task automatic compareCommon(input string tag, input logic w, input logic e, input int lat,
                                 input int rds, input int wrs, input logic [31:0] rd);
        checkOutput({tag, " err"}, 32'(res_err), 32'(e));
        checkOutput({tag, " latency"}, 32'(res_lat), 32'(lat));
        checkOutput({tag, " done/rd_valid"}, {30'b0, res_done, res_rv}, {30'b0, !e, !w && !e});
        checkOutput({tag, " rd_data"}, res_rd, rd);
        checkOutput({tag, " reads"}, 32'(res_reads), 32'(rds));
        checkOutput({tag, " writes"}, 32'(res_writes), 32'(wrs));
        checkOutput({tag, " strobe legality"}, 32'(res_bad), 32'd0);
        checkOutput({tag, " busy profile"}, 32'(res_prof_ok), 32'd1);
        checkOutput({tag, " quiet after"}, 32'(res_quiet_ok), 32'd1);
    endtask

    task automatic runVec(input string tag, input vec_t v);
        applyStimulus(v.w, v.sz, v.uns, v.addr, v.wd);
        compareCommon(tag, v.w, v.exp_err, v.exp_lat, v.exp_rds, v.exp_wrs, v.exp_rd);
        if (v.chk_mem) checkOutput({tag, " mem word"}, mem[v.addr[5:2]], v.exp_mem);
    endtask

    // Reference model: lane positions and extension from plain shift/mask arithmetic.
    task automatic predict(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic e, output int lat, output int rds, output int wrs);
        logic [31:0] idx, word, mask, val;
        logic        sbit;
        int          sh;
        idx = addr >> 2;
        e = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)
            || (idx >= 32'(MEM_WORDS));
        lat = 1; rds = 0; wrs = 0;
        if (e) return;
        word = ref_mem[idx[3:0]];
        sh   = (sz == 2'd0) ? 8 * (3 - int'(addr[1:0])) : 16 * (1 - int'(addr[1]));
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        if (!w) begin
            val = (word >> sh) & mask;
            sbit = (sz == 2'd0) ? val[7] : val[15];
            if (sz == 2'd2) val = word;
            else if (!uns && sbit) val = val | ~mask;
            exp_rd_last = val;
            lat = 3; rds = 1;
        end else if (sz == 2'd2) begin
            ref_mem[idx[3:0]] = wd;
            lat = 2; wrs = 1;
        end else begin
            ref_mem[idx[3:0]] = (word & ~(mask << sh)) | ((wd & mask) << sh);
            lat = 4; rds = 1; wrs = 1;
        end
    endtask

    task automatic modelReq(input int n, input logic w, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd);
        logic  e;
        int    lat, rds, wrs, diffs;
        string tag;
        tag = $sformatf("rand%0d", n);
        predict(w, sz, uns, addr, wd, e, lat, rds, wrs);
        applyStimulus(w, sz, uns, addr, wd);
        compareCommon(tag, w, e, lat, rds, wrs, exp_rd_last);
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) diffs++;
        checkOutput({tag, " mem image diffs"}, 32'(diffs), 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " flags"}, {26'b0, busy, rd_valid, done, err, mem_read, mem_write}, 32'd0);
        checkOutput({tag, " rd_data"}, rd_data, 32'd0);
        checkOutput({tag, " mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   rv_cyc [3];
        logic [31:0] rv_dat [3];
        int   nrv, r0, w0;
        logic w, uns;
        logic [1:0] sz;
        logic [31:0] addr, wd;

        tests_run = 0;
        tests_failed = 0;
        exp_rd_last = 32'h0;

        //          w     sz    uns   addr   wdata         exp_rd        exp_mem       err   chk   lat r  w
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b1, 2, 0, 1};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h12345678, 32'h12345678, 1'b0, 1'b1, 3, 1, 0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h04, 32'h0,        32'hFFFFFF80, 32'h80FF7F01, 1'b0, 1'b1, 3, 1, 0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h05, 32'h0,        32'h000000FF, 32'h80FF7F01, 1'b0, 1'b1, 3, 1, 0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h06, 32'h0,        32'h00007F01, 32'h80FF7F01, 1'b0, 1'b1, 3, 1, 0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h04, 32'h0,        32'hFFFF80FF, 32'h80FF7F01, 1'b0, 1'b1, 3, 1, 0};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h0E, 32'hABCDEF11, 32'hFFFF80FF, 32'hAABB11DD, 1'b0, 1'b1, 4, 1, 1};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0C, 32'h55552233, 32'hFFFF80FF, 32'h223311DD, 1'b0, 1'b1, 4, 1, 1};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,        32'h000011DD, 32'h223311DD, 1'b0, 1'b1, 3, 1, 0};
        vecs[9]  = '{1'b0, 2'd0, 1'b0, 32'h0F, 32'h0,        32'hFFFFFFDD, 32'h223311DD, 1'b0, 1'b1, 3, 1, 0};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        32'hFFFFFFDD, 32'h80FF7F01, 1'b1, 1'b1, 1, 0, 0};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        32'hFFFFFFDD, 32'h00000000, 1'b1, 1'b1, 1, 0, 0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'hFFFFFFDD, 32'h00000000, 1'b1, 1'b1, 1, 0, 0};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h2C, 32'h0,        32'hFFFFFFDD, 32'h0,        1'b1, 1'b0, 1, 0, 0};
        vecs[14] = '{1'b1, 2'd2, 1'b0, 32'h2C, 32'hFFFFFFFF, 32'hFFFFFFDD, 32'h0,        1'b1, 1'b0, 1, 0, 0};
        vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h0D, 32'h0000BEEF, 32'hFFFFFFDD, 32'h223311DD, 1'b1, 1'b1, 1, 0, 0};
        vecs[16] = '{1'b1, 2'd3, 1'b0, 32'h0C, 32'h0000BEEF, 32'hFFFFFFDD, 32'h223311DD, 1'b1, 1'b1, 1, 0, 0};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h28, 32'h0,        32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b1, 3, 1, 0};
        vecs[18] = '{1'b1, 2'd1, 1'b0, 32'h2A, 32'h00001234, 32'h0BADF00D, 32'h0BAD1234, 1'b0, 1'b1, 4, 1, 1};
        vecs[19] = '{1'b0, 2'd0, 1'b1, 32'h2B, 32'h0,        32'h00000034, 32'h0BAD1234, 1'b0, 1'b1, 3, 1, 0};

        for (int i = 0; i < MEM_WORDS; i++) preload(i, 32'h0);
        preload(1, 32'h80FF7F01);
        preload(3, 32'hAABBCCDD);
        preload(10, 32'h0BADF00D);
        @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) runVec($sformatf("vec%0d", i), vecs[i]);

        // Reset while the word-store strobe is high: the write edge never happens.
        preload(0, 32'h01020304);
        @(negedge clk); #1;
        req_write = 1'b1; req_size = 2'd2; req_addr = 32'h0; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rstA write strobe", {31'b0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rstA");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstA mem0 kept", mem[0], 32'h01020304);

        // Reset during the read half of a byte store: memory must stay untouched.
        @(negedge clk); #1;
        req_write = 1'b1; req_size = 2'd0; req_addr = 32'h0D; req_wdata = 32'h99;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rstB read strobe", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rstB");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstB mem3 kept", mem[3], 32'h223311DD);
        runVec("post reset lw", '{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 32'h223311DD, 32'h223311DD,
                                  1'b0, 1'b1, 3, 1, 0});

        // Randomized requests against the reference model.
        for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom());
        exp_rd_last = 32'h223311DD;
        for (int n = 0; n < 100; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 12)) << 2;
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(0, 3));
            else if (sz == 2'd0) addr[1:0] = 2'($urandom_range(0, 3));
            else if (sz == 2'd1) addr[1] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) addr = addr | 32'hFFFF_0000;
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom();
            modelReq(n, w, sz, uns, addr, wd);
        end

        // req_valid held high across three loads: each is taken only from IDLE.
        @(negedge clk); #1;
        r0 = read_cnt; w0 = write_cnt;
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        nrv = 0;
        for (int i = 0; i < 3; i++) begin rv_cyc[i] = 0; rv_dat[i] = 32'h0; end
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 11) req_valid = 1'b0;
            if (rd_valid) begin
                if (nrv < 3) begin rv_cyc[nrv] = c; rv_dat[nrv] = rd_data; end
                nrv++;
            end
        end
        #1;
        checkOutput("b2b rd_valid count", 32'(nrv), 32'd3);
        checkOutput("b2b first cycle", 32'(rv_cyc[0]), 32'd3);
        checkOutput("b2b second cycle", 32'(rv_cyc[1]), 32'd7);
        checkOutput("b2b third cycle", 32'(rv_cyc[2]), 32'd11);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("b2b data%0d", i), rv_dat[i], ref_mem[4]);
        checkOutput("b2b reads", 32'(read_cnt - r0), 32'd3);
        checkOutput("b2b writes", 32'(write_cnt - w0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
